// File: rtl/mem_copy_dma_if.sv
// mem_copy_dma_if: request and data-memory port bundle for mem_copy_dma.
// The master modport is the DMA engine; the slave modport is the requester plus
// memory side. The fill/fill_val signals exist only when DMA_FILL_EN is defined.
interface mem_copy_dma_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
);
    // Request side
    logic             start;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
`ifdef DMA_FILL_EN
    logic             fill;
    logic [31:0]      fill_val;
`endif

    // Data-memory side
    logic [31:0]      addr;
    logic [31:0]      wrData;
    logic             wrMem;
    logic             rdMem;
    logic [31:0]      rdData;

`ifdef DMA_FILL_EN
    modport master (
        input  start, src, dst, len, fill, fill_val, rdData,
        output busy, done, addr, wrData, wrMem, rdMem
    );

    modport slave (
        output start, src, dst, len, fill, fill_val, rdData,
        input  busy, done, addr, wrData, wrMem, rdMem
    );
`else
    modport master (
        input  start, src, dst, len, rdData,
        output busy, done, addr, wrData, wrMem, rdMem
    );

    modport slave (
        output start, src, dst, len, rdData,
        input  busy, done, addr, wrData, wrMem, rdMem
    );
`endif
endinterface

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: copies len words from src to dst on the data-memory port, in
// ascending order, one read then one write per word (2 cycles/word). Addresses
// wrap modulo 2^ADDR_W. Define DMA_FILL_EN to add a fill mode that writes a
// latched constant to len consecutive words at 1 cycle/word with no reads.
// ADDR_W must be below 32.
module mem_copy_dma #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    mem_copy_dma_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  i_q, i_d;

    logic              fill_mode;   // latched fill request (0 in copy-only build)
    logic              start_fill;  // fill request presented with start
    logic [31:0]       fill_data;   // latched fill word

`ifdef DMA_FILL_EN
    logic              fill_q, fill_d;
    logic [31:0]       fill_val_q, fill_val_d;

    assign fill_mode  = fill_q;
    assign start_fill = bus.fill;
    assign fill_data  = fill_val_q;
`else
    assign fill_mode  = 1'b0;
    assign start_fill = 1'b0;
    assign fill_data  = '0;
`endif

    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              last_word;

    // Word offsets wrap with the address space, so only the low ADDR_W bits of i matter.
    assign i_addr    = ADDR_W'(i_q);
    assign rd_addr   = src_q + i_addr;
    assign wr_addr   = dst_q + i_addr;
    // len_q is never 0 while in WR, so len_q-1 cannot underflow where it is used.
    assign last_word = (i_q == len_q - LEN_W'(1));

    // State and datapath registers; asynchronous reset aborts any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            i_q        <= '0;
`ifdef DMA_FILL_EN
            fill_q     <= 1'b0;
            fill_val_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            i_q        <= i_d;
`ifdef DMA_FILL_EN
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
`endif
        end
    end

    // Next-state logic: latch the request in IDLE, step i after each write.
    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a variable unassigned (no latches).
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        i_d        = i_q;
`ifdef DMA_FILL_EN
        fill_d     = fill_q;
        fill_val_d = fill_val_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d      = bus.src[ADDR_W-1:0];
                    dst_d      = bus.dst[ADDR_W-1:0];
                    len_d      = bus.len;
                    i_d        = '0;
`ifdef DMA_FILL_EN
                    fill_d     = bus.fill;
                    fill_val_d = bus.fill_val;
`endif
                    if (bus.len == '0) begin
                        state_d = DONE;
                    end else if (start_fill) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = WR;
            end
            WR: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + LEN_W'(1);
                    state_d = fill_mode ? WR : RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state; write data passes rdData straight through in copy mode.
    always_comb begin
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.addr   = '0;
        bus.wrData = '0;
        bus.wrMem  = 1'b0;
        bus.rdMem  = 1'b0;
        unique case (state_q)
            RD: begin
                bus.busy  = 1'b1;
                bus.rdMem = 1'b1;
                bus.addr  = 32'(rd_addr);
            end
            WR: begin
                bus.busy   = 1'b1;
                bus.wrMem  = 1'b1;
                bus.addr   = 32'(wr_addr);
                bus.wrData = fill_mode ? fill_data : bus.rdData;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
